// File: rtl/load_gen_scheduler.sv
// Round-robin burst scheduler for the load data generator: picks a channel per frame,
// counts generator words to find frame ends, and controls generator reset and FIFO-ready.
module load_gen_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              burst_frames,
    input  logic [NCH-1:0]           ch_enable,
    input  logic [NCH*16-1:0]        ch_flag,
    input  logic [NCH*24-1:0]        ch_length,
    input  logic                     fifo_ready,
    input  logic                     gen_data_en,
    output logic                     gen_nrst,
    output logic                     gen_fifo_ready,
    output logic [15:0]              flag_set,
    output logic [23:0]              length_set,
    output logic [$clog2(NCH)-1:0]   cur_ch,
    output logic                     busy,
    output logic                     frame_done,
    output logic [31:0]              frames_sent,
    output logic                     err_cfg,
    output logic                     err_timeout
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSelect, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic [15:0]     flag_q, flag_d;
    logic [15:0]     burst_q, burst_d;
    logic [23:0]     length_q, length_d;
    logic [22:0]     word_cnt_q, word_cnt_d;
    logic [31:0]     frames_q, frames_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            err_cfg_q, err_cfg_d;
    logic            err_to_q, err_to_d;
    logic            frame_done_q, frame_done_d;
    logic            gen_nrst_q, gen_nrst_d;
    logic            busy_q, busy_d;
    logic            run_q, run_d;

    // Channel search starting at ptr_q; invalid enabled channels seen before the winner flag cfg.
    logic            found;
    logic            cfg_bad;
    logic [CW-1:0]   win_idx;
    logic [CW-1:0]   idx;
    logic [23:0]     len;

    always_comb begin
        found   = 1'b0;
        cfg_bad = 1'b0;
        win_idx = '0;
        idx     = '0;
        len     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = CW'((32'(ptr_q) + k) % NCH);
            len = ch_length[32'(idx)*24 +: 24];
            if (!found && ch_enable[idx]) begin
                if (!len[0] && len >= 24'd14) begin
                    found   = 1'b1;
                    win_idx = idx;
                end else begin
                    cfg_bad = 1'b1;
                end
            end
        end
    end

    assign gen_fifo_ready = fifo_ready & run_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_ch_d     = cur_ch_q;
        flag_d       = flag_q;
        burst_d      = burst_q;
        length_d     = length_q;
        word_cnt_d   = word_cnt_q;
        frames_d     = frames_q;
        stall_d      = stall_q;
        err_cfg_d    = err_cfg_q;
        err_to_d     = err_to_q;
        frame_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    frames_d  = '0;
                    err_cfg_d = 1'b0;
                    err_to_d  = 1'b0;
                    ptr_d     = '0;
                    state_d   = StSelect;
                end
            end
            StSelect: begin
                if (cfg_bad) begin
                    err_cfg_d = 1'b1;
                end
                if (abort) begin
                    state_d = StDone;
                end else if (found) begin
                    flag_d     = ch_flag[32'(win_idx)*16 +: 16];
                    length_d   = ch_length[32'(win_idx)*24 +: 24];
                    cur_ch_d   = win_idx;
                    burst_d    = burst_frames;
                    word_cnt_d = '0;
                    stall_d    = '0;
                    state_d    = StRun;
                end else begin
                    state_d = StDone;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StDone;
                end else if (gen_data_en) begin
                    stall_d    = '0;
                    word_cnt_d = word_cnt_q + 23'd1;
                    if (word_cnt_q == length_q[23:1] - 23'd1) begin
                        frame_done_d = 1'b1;
                        frames_d     = (&frames_q) ? frames_q : frames_q + 32'd1;
                        ptr_d        = (cur_ch_q == CW'(NCH - 1)) ? '0 : cur_ch_q + CW'(1);
                        if (burst_q != 16'd0 && frames_d == {16'd0, burst_q}) begin
                            state_d = StDone;
                        end else begin
                            state_d = StSelect;
                        end
                    end
                end else if (gen_fifo_ready) begin
                    stall_d = stall_q + SW'(1);
                    if (stall_d == SW'(TIMEOUT)) begin
                        err_to_d = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Generator stays out of reset through SELECT between frames of a running burst.
        run_d      = (state_d == StRun);
        busy_d     = (state_d == StSelect) || (state_d == StRun);
        gen_nrst_d = run_d || ((state_d == StSelect) && (state_q == StRun));
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cur_ch_q     <= '0;
            flag_q       <= '0;
            burst_q      <= '0;
            length_q     <= '0;
            word_cnt_q   <= '0;
            frames_q     <= '0;
            stall_q      <= '0;
            err_cfg_q    <= 1'b0;
            err_to_q     <= 1'b0;
            frame_done_q <= 1'b0;
            gen_nrst_q   <= 1'b0;
            busy_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_ch_q     <= cur_ch_d;
            flag_q       <= flag_d;
            burst_q      <= burst_d;
            length_q     <= length_d;
            word_cnt_q   <= word_cnt_d;
            frames_q     <= frames_d;
            stall_q      <= stall_d;
            err_cfg_q    <= err_cfg_d;
            err_to_q     <= err_to_d;
            frame_done_q <= frame_done_d;
            gen_nrst_q   <= gen_nrst_d;
            busy_q       <= busy_d;
            run_q        <= run_d;
        end
    end

    assign gen_nrst    = gen_nrst_q;
    assign flag_set    = flag_q;
    assign length_set  = length_q;
    assign cur_ch      = cur_ch_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_q;
    assign err_cfg     = err_cfg_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_load_gen_scheduler.sv
// Scoreboard bench for load_gen_scheduler: expected frames are queued at stimulus time and
// checked by a monitor on each frame_done pulse.
module tb_load_gen_scheduler;

    localparam int unsigned NCH = 4;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start, abort;
    logic [15:0] burst_frames;
    logic [3:0]  ch_enable;
    logic [63:0] ch_flag;
    logic [95:0] ch_length;
    logic        fifo_ready, gen_data_en;
    logic        gen_nrst, gen_fifo_ready, busy, frame_done, err_cfg, err_timeout;
    logic [15:0] flag_set;
    logic [23:0] length_set;
    logic [1:0]  cur_ch;
    logic [31:0] frames_sent;

    load_gen_scheduler #(.NCH(NCH), .TIMEOUT(1024)) dut (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort), .burst_frames(burst_frames),
        .ch_enable(ch_enable), .ch_flag(ch_flag), .ch_length(ch_length),
        .fifo_ready(fifo_ready), .gen_data_en(gen_data_en), .gen_nrst(gen_nrst),
        .gen_fifo_ready(gen_fifo_ready), .flag_set(flag_set), .length_set(length_set),
        .cur_ch(cur_ch), .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent),
        .err_cfg(err_cfg), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned ch;
        int unsigned flag;
        int unsigned len;
        int unsigned frames;
        int unsigned words;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned words_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (gen_data_en) words_seen <= words_seen + 1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (nRST && frame_done) begin
            if (sb.size() == 0) begin
                chk("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("frame_cur_ch", {30'd0, cur_ch}, e.ch);
                chk("frame_flag", {16'd0, flag_set}, e.flag);
                chk("frame_length", {8'd0, length_set}, e.len);
                chk("frame_frames_sent", frames_sent, e.frames);
                chk("frame_word_position", words_seen, e.words);
            end
        end
    end

    function automatic logic [15:0] flag_of(input int i);
        return 16'hA000 + 16'(i);
    endfunction

    task automatic set_ch(input int i, input logic [23:0] len);
        ch_length[24*i +: 24] = len;
        ch_flag[16*i +: 16]   = flag_of(i);
    endtask

    task automatic push(input int ch, input int len, input int frames, input int words);
        exp_t e;
        e.ch = ch; e.flag = 32'(flag_of(ch)); e.len = len; e.frames = frames; e.words = words;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after pulse_start; returns cycles from the start edge to gen_nrst=1.
    task automatic wait_run(output int cycles);
        int n = 0;
        while (!gen_nrst && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!gen_nrst) chk("wait_gen_nrst_bound", {31'd0, gen_nrst}, 32'd1);
        cycles = n + 1;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            gen_data_en = 1'b1;
            @(negedge clk);
        end
        gen_data_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gen_nrst"}, {31'd0, gen_nrst}, 32'd0);
        chk({tag, "_gen_fifo_ready"}, {31'd0, gen_fifo_ready}, 32'd0);
        chk({tag, "_flag_set"}, {16'd0, flag_set}, 32'd0);
        chk({tag, "_length_set"}, {8'd0, length_set}, 32'd0);
        chk({tag, "_cur_ch"}, {30'd0, cur_ch}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_frames_sent"}, frames_sent, 32'd0);
        chk({tag, "_err_cfg"}, {31'd0, err_cfg}, 32'd0);
        chk({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          words;
        int unsigned base;
        nRST = 1'b0; start = 1'b0; abort = 1'b0; burst_frames = '0;
        ch_enable = '0; ch_flag = '0; ch_length = '0;
        fifo_ready = 1'b1; gen_data_en = 1'b0;
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        nRST = 1'b1;
        tick(2);

        // Two channels alternating, burst of 4 frames
        ch_enable = 4'b0101;
        set_ch(0, 24'd64); set_ch(1, 24'd14); set_ch(2, 24'd32); set_ch(3, 24'd100);
        burst_frames = 16'd4;
        base = words_seen;
        push(0, 64, 1, base + 32); push(2, 32, 2, base + 48);
        push(0, 64, 3, base + 80); push(2, 32, 4, base + 96);
        pulse_start();
        wait_run(cyc);
        chk("rr_start_to_gen_nrst", 32'(cyc), 32'd2);
        chk("rr_busy", {31'd0, busy}, 32'd1);
        send_words(32); tick(14);
        send_words(16); tick(14);
        send_words(32); tick(14);
        send_words(16);
        chk("rr_done_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("rr_done_busy", {31'd0, busy}, 32'd0);
        tick(3);
        chk("rr_frames_sent_final", frames_sent, 32'd4);
        chk("rr_err_cfg", {31'd0, err_cfg}, 32'd0);
        chk("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Continuous burst on channel 1, abort mid-frame 3
        ch_enable = 4'b0010; set_ch(1, 24'd20); burst_frames = 16'd0;
        base = words_seen;
        push(1, 20, 1, base + 10); push(1, 20, 2, base + 20);
        pulse_start();
        wait_run(cyc);
        send_words(10); tick(14);
        send_words(10); tick(14);
        send_words(7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
        chk("abort_frames_sent", frames_sent, 32'd2);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick(2);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Only enabled channel has an odd length
        ch_enable = 4'b0010; set_ch(1, 24'd15);
        pulse_start();
        chk("cfg_select_busy", {31'd0, busy}, 32'd1);
        chk("cfg_select_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        @(negedge clk);
        chk("cfg_done_busy", {31'd0, busy}, 32'd0);
        chk("cfg_done_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("cfg_err_cfg", {31'd0, err_cfg}, 32'd1);
        @(negedge clk);
        chk("cfg_idle_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("cfg_err_cfg_sticky", {31'd0, err_cfg}, 32'd1);

        // Generator stall with fifo_ready held high
        ch_enable = 4'b0001; set_ch(0, 24'd64); burst_frames = 16'd1; fifo_ready = 1'b1;
        pulse_start();
        wait_run(cyc);
        chk("to_err_cfg_cleared", {31'd0, err_cfg}, 32'd0);
        tick(1023);
        chk("to_before_gen_nrst", {31'd0, gen_nrst}, 32'd1);
        chk("to_before_err", {31'd0, err_timeout}, 32'd0);
        tick(1);
        chk("to_gen_nrst", {31'd0, gen_nrst}, 32'd0);
        chk("to_err", {31'd0, err_timeout}, 32'd1);
        chk("to_frames_sent", frames_sent, 32'd0);
        tick(1);
        chk("to_idle_busy", {31'd0, busy}, 32'd0);
        chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

        // fifo_ready pattern, single 256-byte frame on channel 3
        ch_enable = 4'b1000; set_ch(3, 24'd256); burst_frames = 16'd1; fifo_ready = 1'b1;
        #1;
        chk("fr_idle_gated", {31'd0, gen_fifo_ready}, 32'd0);
        @(negedge clk);
        base = words_seen;
        push(3, 256, 1, base + 128);
        pulse_start();
        wait_run(cyc);
        words = 0;
        cyc = 0;
        while (words < 128 && cyc < 2000) begin
            fifo_ready = ((cyc * 5) % 7) < 4;
            #1;
            chk("fr_run_tracks", {31'd0, gen_fifo_ready}, {31'd0, fifo_ready});
            gen_data_en = gen_fifo_ready;
            if (gen_fifo_ready) words++;
            cyc++;
            @(negedge clk);
        end
        gen_data_en = 1'b0;
        fifo_ready  = 1'b1;
        #1;
        chk("fr_done_gated", {31'd0, gen_fifo_ready}, 32'd0);
        tick(3);
        chk("fr_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-frame, then restart
        ch_enable = 4'b0101; set_ch(0, 24'd64); set_ch(2, 24'd32); burst_frames = 16'd0;
        base = words_seen;
        push(0, 64, 1, base + 32);
        pulse_start();
        wait_run(cyc);
        send_words(32); tick(14);
        send_words(5);
        fifo_ready = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        chk("async_rst_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        tick(1);
        base = words_seen;
        push(0, 64, 1, base + 32);
        pulse_start();
        wait_run(cyc);
        chk("restart_cur_ch", {30'd0, cur_ch}, 32'd0);
        chk("restart_frames_sent", frames_sent, 32'd0);
        send_words(32); tick(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tick(2);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);
        chk("restart_idle_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_gen_scheduler.md
# load_gen_scheduler

Burst scheduler for the load data generator. It arbitrates up to NCH configured traffic channels round-robin onto the single generator instance. For each frame it presents the winning channel's flag/length, and counts generator output words to find frame boundaries. It also releases or holds the generator through its reset, gates its FIFO-ready input, and flags configuration and stall errors.

## Interface
- NCH, 4: number of traffic channels (2..8); CW = clog2(NCH).
- TIMEOUT, 1024: maximum cycles without a generator word while ready, before a stall error.
- clk  in  1  system clock
- nRST  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse; begin a burst (ignored while busy)
- abort  in  1  one-cycle pulse; end the burst immediately
- burst_frames  in  16  frames per burst; 0 = continuous until abort
- ch_enable  in  NCH  per-channel enable, sampled in SELECT
- ch_flag  in  NCH*16  per-channel payload flag; channel i is at [16i+15:16i]
- ch_length  in  NCH*24  per-channel frame length in bytes; channel i is at [24i+23:24i]
- fifo_ready  in  1  downstream FIFO can accept data
- gen_data_en  in  1  generator output word strobe
- gen_nrst  out  1  generator reset, active low
- gen_fifo_ready  out  1  gated FIFO-ready to the generator
- flag_set  out  16  flag of the active channel
- length_set  out  24  length of the active channel
- cur_ch  out  CW  active channel index
- busy  out  1  burst in progress
- frame_done  out  1  one-cycle pulse per completed frame
- frames_sent  out  32  frames completed this burst (saturating)
- err_cfg  out  1  sticky: an enabled channel had an invalid length
- err_timeout  out  1  sticky: generator stall detected

## Operation
- Reset values: all outputs are 0, including gen_nrst. State is IDLE and the round-robin pointer is 0.
- A length is valid when it is even and ≥ 14. The frame word count is length_set[23:1]: 6 header words, (L−14)/2 data words and 1 CRC word.
- **IDLE**
  - gen_nrst=0, busy=0.
  - On start: clear frames_sent, err_cfg and err_timeout; set the search pointer to ch 0; go to SELECT.
- **SELECT** (1 cycle)
  - Search channels ptr, ptr+1, … (mod NCH) and take the first one that is enabled with a valid length.
  - An enabled channel with an invalid length is skipped and sets err_cfg.
  - If a winner exists: register flag_set, length_set and cur_ch; clear word_cnt; go to RUN.
  - If there is no winner: go to DONE.
- **RUN**
  - gen_nrst=1, busy=1, gen_fifo_ready = fifo_ready.
  - Each gen_data_en cycle increments word_cnt.
  - When gen_data_en arrives with word_cnt == length_set[23:1]−1, the frame is complete:
    - pulse frame_done;
    - frames_sent += 1, saturating at 0xFFFFFFFF;
    - set ptr = cur_ch+1 (mod NCH).
  - After frame completion: if burst_frames ≠ 0 and frames_sent reaches burst_frames, go to DONE; otherwise go to SELECT. gen_nrst stays 1, so the generator sequence count keeps running.
  - Stall counter: counts cycles with gen_fifo_ready=1 and gen_data_en=0; it clears on any gen_data_en. When it reaches TIMEOUT: set err_timeout and go to DONE with no frame_done.
- **DONE** (1 cycle)
  - gen_nrst=0, gen_fifo_ready=0, busy=0, then go to IDLE.
  - flag_set, length_set and cur_ch hold their values.
- Abort in SELECT or RUN goes to DONE on the next edge. No frame_done is issued for the partial frame, and frames_sent is unchanged.
- Abort is ignored in IDLE.
- If start and abort arrive together in IDLE, start wins.
- Config inputs may change at any time. Only the values sampled in SELECT are used.

## Timing
- All outputs are registered except gen_fifo_ready, which is fifo_ready AND a registered run flag.
- start to gen_nrst=1: 2 cycles (IDLE→SELECT→RUN).
- The frame_done pulse comes 1 cycle after the final gen_data_en.
- flag_set and length_set update 2 cycles after the final word of a frame. This lands inside the generator's ≥12-cycle CRC/turnaround gap, before the next header.
- Abort at edge n: gen_nrst=0 at n+1.
- Asynchronous nRST mid-burst: all outputs return to their reset values immediately, and the state goes to IDLE.

## Test plan
- NCH=4, ch_enable=0101, ch_length[0]=64, ch_length[2]=32, burst_frames=4 → cur_ch goes 0,2,0,2. frame_done follows the 32nd and 16th words in turn. frames_sent=4, then gen_nrst=0 and busy=0.
- burst_frames=0, ch 1 only, length 20; abort after word 7 of frame 3 → gen_nrst=0 next cycle, no frame_done, frames_sent=2.
- ch_enable=0010 with ch_length[1]=15 → err_cfg=1, gen_nrst is never 1, busy drops after 2 cycles.
- Hold gen_data_en=0 with fifo_ready=1 for 1024 cycles in RUN → err_timeout=1, DONE then IDLE, no frame_done.
- Toggle fifo_ready at random, length 256 → gen_fifo_ready tracks fifo_ready only in RUN, and frame_done comes exactly after the 128th word.
- Assert nRST mid-frame → all outputs 0 at once; a new start then restarts from ch 0 with frames_sent=0.
